// File: rtl/mmio_out_fifo_if.sv
// Bus-side and stream-side signals of the memory-mapped output FIFO.
// The shared tristate data net is a direct port on the block.
interface mmio_out_fifo_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  chip_select_in;
  logic                  write_enable;
  logic                  output_enable;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output addr,
    output chip_select_in,
    output write_enable,
    output output_enable,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  addr,
    input  chip_select_in,
    input  write_enable,
    input  output_enable,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/mmio_out_fifo.sv
// Memory-mapped output FIFO: CPU stores to DATA push words, a valid/ready
// stream drains them, STATUS exposes fill level and a sticky overflow flag.
module mmio_out_fifo #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'hF00,
  parameter int                    DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] data,
  mmio_out_fifo_if.slave        bus
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [1:0]        OFF_DATA   = 2'd0;
  localparam logic [1:0]        OFF_STATUS = 2'd1;
  localparam logic [1:0]        OFF_CTRL   = 2'd2;

  logic                  hit;
  logic [1:0]            offset;
  logic                  wr;
  logic                  rd;
  logic                  unused_addr_lsb;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rd_reg_q, rd_reg_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] status;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  push_acc;
  logic                  flush;
  logic                  ovf_clr;

  assign hit             = (bus.addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
  assign offset          = bus.addr[2:1];
  assign unused_addr_lsb = bus.addr[0];

  // A cycle with both strobes high is a bus conflict: neither access happens.
  assign wr = hit & bus.chip_select_in & bus.write_enable  & ~bus.output_enable;
  assign rd = hit & bus.chip_select_in & bus.output_enable & ~bus.write_enable;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign push     = wr & (offset == OFF_DATA);
  assign pop      = ~empty & bus.out_ready;
  assign push_acc = push & (~full | pop);
  assign flush    = wr & (offset == OFF_CTRL) & data[0];
  assign ovf_clr  = wr & (offset == OFF_CTRL) & data[1];

  assign bus.out_valid = ~empty;
  assign bus.out_data  = out_data_q;

  // Released combinationally by rst so the bus frees up before any clock.
  assign data = (rd & ~rst) ? rd_reg_q : 'z;

  always_comb begin
    status     = '0;
    status[15] = ovf_q;
    status[14] = full;
    status[13] = empty;
    status[7:0] = 8'(count_q);

    rd_reg_d = rd_reg_q;
    if (rd) begin
      rd_reg_d = (offset == OFF_STATUS) ? status : '0;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push & full & ~pop) ovf_d = 1'b1;
    if (ovf_clr)            ovf_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // The next head may be the word being written this very edge.
    if (flush) begin
      out_data_d = '0;
    end else if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = data;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_reg_q   <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_reg_q   <= rd_reg_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_FULL);

  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready && !flush) |=> $stable(bus.out_data));

endmodule

// File: tb/tb_mmio_out_fifo.sv
// Randomized bench for mmio_out_fifo against a queue-based reference model.
module tb_mmio_out_fifo;
  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tb_en;
  logic [DW-1:0] tb_val;
  logic          cmp_en = 1'b0;
  wire  [DW-1:0] data;

  assign data = tb_en ? tb_val : 'z;

  mmio_out_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mmio_out_fifo #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BASE_ADDR (12'hF00),
    .DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .data(data),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: the FIFO is a queue, the read register is the last value read.
  logic [DW-1:0] mq[$];
  logic          m_ovf;
  logic [DW-1:0] m_rdreg;
  logic [1:0]    m_off;
  logic          m_rd, m_wr, m_pop, m_full;

  function automatic logic m_hit(input logic [AW-1:0] a);
    return a[AW-1:3] == 9'h1E0;
  endfunction

  function automatic logic [15:0] m_status();
    int sz = mq.size();
    return {m_ovf, sz == DEPTH, sz == 0, 5'b0, 8'(sz)};
  endfunction

  always_comb begin
    m_rd = m_hit(bus_if.addr) && bus_if.chip_select_in && bus_if.output_enable
           && !bus_if.write_enable;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_rdreg = '0;
    end else begin
      m_off  = bus_if.addr[2:1];
      m_wr   = m_hit(bus_if.addr) && bus_if.chip_select_in && bus_if.write_enable
               && !bus_if.output_enable;
      m_pop  = (mq.size() != 0) && bus_if.out_ready;
      m_full = (mq.size() == DEPTH);
      if (m_rd) m_rdreg = (m_off == 2'd1) ? m_status() : '0;
      if (m_wr && m_off == 2'd2 && data[0]) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_wr && m_off == 2'd0) begin
          if (!m_full || m_pop) mq.push_back(data);
          else m_ovf = 1'b1;
        end
      end
      if (m_wr && m_off == 2'd2 && data[1]) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("out_valid", 32'(bus_if.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", 32'(bus_if.out_data), 32'(mq[0]));
      if (m_rd) chk("rd_data", 32'(data), 32'(m_rdreg));
      else if (tb_en) chk("bus_hiz", 32'(data), 32'(tb_val));
    end
  end

  task automatic idle();
    bus_if.addr           = '0;
    bus_if.chip_select_in = 1'b0;
    bus_if.write_enable   = 1'b0;
    bus_if.output_enable  = 1'b0;
    tb_en  = 1'b1;
    tb_val = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bus_if.addr           = a;
    bus_if.chip_select_in = 1'b1;
    bus_if.write_enable   = 1'b1;
    bus_if.output_enable  = 1'b0;
    tb_en  = 1'b1;
    tb_val = v;
    step();
    idle();
  endtask

  // Non-window reads model large_ram answering with zero on the shared bus.
  task automatic bus_rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
    bus_if.addr           = a;
    bus_if.chip_select_in = 1'b1;
    bus_if.write_enable   = 1'b0;
    bus_if.output_enable  = 1'b1;
    tb_en  = !m_hit(a);
    tb_val = '0;
    @(posedge clk);
    @(negedge clk);
    v = data;
    step();
    idle();
  endtask

  task automatic bus_conflict();
    bus_if.addr           = 12'hF02;
    bus_if.chip_select_in = 1'b1;
    bus_if.write_enable   = 1'b1;
    bus_if.output_enable  = 1'b1;
    tb_en  = 1'b1;
    tb_val = '0;
    step();
    idle();
  endtask

  logic [DW-1:0] v;
  int            op;

  initial begin
    idle();
    bus_if.out_ready = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    chk("rst_valid", 32'(bus_if.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus_if.out_data), 32'h0);
    bus_rd(12'hF02, v);
    chk("status_reset", 32'(v), 32'h2000);

    bus_wr(12'hF00, 16'h0001);
    chk("first_push_valid", 32'(bus_if.out_valid), 32'h1);
    chk("first_push_data", 32'(bus_if.out_data), 32'h0001);
    bus_wr(12'hF00, 16'h0001);
    bus_wr(12'hF00, 16'h0002);
    bus_rd(12'hF02, v);
    chk("status_three", 32'(v), 32'h0003);
    bus_if.out_ready = 1'b1;
    repeat (3) step();
    chk("drained_valid", 32'(bus_if.out_valid), 32'h0);

    bus_wr(12'hF00, 16'h0003);
    chk("thru_head3", 32'(bus_if.out_data), 32'h0003);
    bus_wr(12'hF00, 16'h0005);
    chk("thru_head5", 32'(bus_if.out_data), 32'h0005);
    step();
    chk("thru_empty", 32'(bus_if.out_valid), 32'h0);
    bus_if.out_ready = 1'b0;

    for (int i = 0; i < 8; i++) bus_wr(12'hF00, 16'h1000 + 16'(i));
    bus_wr(12'hF00, 16'hFFFF);
    bus_rd(12'hF02, v);
    chk("status_overflow", 32'(v), 32'hC008);
    bus_if.out_ready = 1'b1;
    bus_wr(12'hF00, 16'h2000);
    bus_if.out_ready = 1'b0;
    chk("full_pushpop_head", 32'(bus_if.out_data), 32'h1001);
    bus_rd(12'hF02, v);
    chk("status_full_pushpop", 32'(v), 32'hC008);
    bus_wr(12'hF04, 16'h0003);
    chk("flush_valid", 32'(bus_if.out_valid), 32'h0);
    bus_rd(12'hF02, v);
    chk("status_flushed", 32'(v), 32'h2000);

    for (int i = 0; i < 8; i++) bus_wr(12'hF01, 16'h1000 + 16'(i));
    bus_wr(12'hF00, 16'hFFFF);
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(bus_if.out_data), 32'h1000 + 32'(i));
      step();
    end
    bus_if.out_ready = 1'b0;
    chk("drain_done", 32'(bus_if.out_valid), 32'h0);
    bus_rd(12'hF03, v);
    chk("status_ovf_empty", 32'(v), 32'hA000);
    bus_wr(12'hF04, 16'h0002);
    bus_rd(12'hF02, v);
    chk("status_ovf_clr", 32'(v), 32'h2000);

    bus_wr(12'hF00, 16'h0042);
    bus_rd(12'hF02, v);
    bus_wr(12'hF08, 16'h1234);
    bus_wr(12'h100, 16'h5678);
    bus_rd(12'hF08, v);
    bus_rd(12'h100, v);
    bus_conflict();
    bus_wr(12'hF06, 16'hFFFF);
    bus_rd(12'hF06, v);
    chk("reserved_read", 32'(v), 32'h0);
    bus_rd(12'hF02, v);
    chk("status_after_nonhit", 32'(v), 32'h0001);
    chk("head_after_nonhit", 32'(bus_if.out_data), 32'h0042);

    bus_wr(12'hF00, 16'h0002);
    bus_if.addr           = 12'hF02;
    bus_if.chip_select_in = 1'b1;
    bus_if.output_enable  = 1'b1;
    tb_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rd_before_reset", 32'(data), 32'h0002);
    #1;
    rst    = 1'b1;
    tb_en  = 1'b1;
    tb_val = '0;
    #1;
    chk("async_rst_valid", 32'(bus_if.out_valid), 32'h0);
    chk("async_rst_data", 32'(data), 32'h0);
    chk("async_rst_out_data", 32'(bus_if.out_data), 32'h0);
    idle();
    step();
    rst = 1'b0;
    bus_rd(12'hF02, v);
    chk("status_after_rst", 32'(v), 32'h2000);

    for (int n = 0; n < 600; n++) begin
      bus_if.out_ready = ($urandom_range(0, 2) == 0);
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2, 3, 4: bus_wr(12'hF00 | 12'($urandom_range(0, 1)), 16'($urandom));
        5: bus_rd(12'hF02 | 12'($urandom_range(0, 1)), v);
        6: bus_wr(12'hF04, ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'h0002);
        7: if ($urandom_range(0, 1) == 1) bus_wr(12'hF06, 16'($urandom));
           else if ($urandom_range(0, 1) == 1) bus_wr(12'hF02, 16'($urandom));
           else bus_rd(12'hF06, v);
        8: if ($urandom_range(0, 1) == 1)
             bus_wr(12'($urandom_range(0, 12'hEFF)), 16'($urandom));
           else
             bus_rd(12'hF08 + 12'($urandom_range(0, 12'hF7)), v);
        default: if ($urandom_range(0, 1) == 1) bus_conflict(); else step();
      endcase
    end

    bus_if.out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("final_empty", 32'(bus_if.out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mmio_out_fifo.md
Name: mmio_out_fifo

Overview:
Memory-mapped output port that responds on the shared CPU memory bus (addr, tristate data, chip_select_in, write_enable, output_enable), alongside large_ram.
CPU stores to the DATA register push 16-bit words into a DEPTH-entry FIFO.
The FIFO drains to a downstream consumer over a valid/ready stream, so programs such as Fibonacci can emit results without the bench polling RAM.
A STATUS register lets the CPU read fill level and overflow.

Parameters:
ADDR_WIDTH, 12, bus address width
DATA_WIDTH, 16, bus and FIFO word width
BASE_ADDR, 'hF00, window base; must be 8-aligned
DEPTH, 8, FIFO entries; power of two, 2..128

Ports:
clk  input  1  bus clock; all state changes on posedge
rst  input  1  asynchronous, active-high reset
addr  input  ADDR_WIDTH  byte address from the CPU MAR
data  inout  DATA_WIDTH  shared tristate data bus
chip_select_in  input  1  bus select
write_enable  input  1  bus write strobe
output_enable  input  1  bus read strobe
out_data  output  DATA_WIDTH  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle

Behaviour:
- Reset: clk and rst as decided (one clock; asynchronous, active-high reset).
  - rst clears rd/wr pointers, count=0, overflow=0, rd_reg=0, out_valid=0, out_data=0.
  - data is released to hi-Z immediately, without waiting for a clock.
  - Reset mid-operation discards FIFO contents and any in-flight read.
- Address decode:
  - hit = addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3].
  - offset = addr[2:1]; addr[0] is ignored.
  - No hit: the block never drives data and ignores strobes.
- Register map:
  - off 0 DATA: write pushes; read returns 0.
  - off 1 STATUS (read-only): [15] overflow, [14] full, [13] empty, [7:0] count, other bits 0.
  - off 2 CTRL (write-only): bit0 = flush FIFO, bit1 = clear overflow.
  - off 3: reserved; writes ignored, reads return 0.
- Bus write: wr = hit & chip_select_in & write_enable & !output_enable, sampled at posedge.
- Bus read:
  - rd = hit & chip_select_in & output_enable & !write_enable.
  - At posedge with rd, rd_reg <= register value at offset.
  - data is driven with rd_reg whenever rd is true; hi-Z otherwise.
  - Read latency: addr presented at edge N gives valid data after edge N+1. The CPU samples at edge N+2.
  - write_enable & output_enable both high: no read and no write (bus conflict; the block stays hi-Z).
- FIFO:
  - push = wr & offset==0; pop = out_valid & out_ready.
  - No fall-through: a push into an empty FIFO raises out_valid at the next edge.
  - out_data = mem[rd_ptr], registered/stable while out_valid & !out_ready.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - full = count==DEPTH; empty = count==0.
  - push & pop same cycle, not empty: both occur, count unchanged.
  - push & pop same cycle when full: both occur; the push is accepted and count stays DEPTH.
  - push when full without pop: word dropped, overflow <= 1 (sticky).
  - pop when empty: impossible (out_valid=0).
  - CTRL flush: pointers and count go to 0 at that edge and override a same-cycle pop. out_valid falls at the same edge.
  - CTRL bit1 clears overflow. Overflow set and clear in the same edge cannot occur (single bus op per cycle).
- STATUS reflects state before the sampling edge; it does not include a same-edge push.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> data hi-Z, out_valid=0 immediately. Read STATUS at 'hF02 -> 'h2000 (empty, count 0).
- Push 'h0001,'h0001,'h0002 to 'hF00 with out_ready=0 -> out_valid rises the edge after the first push, out_data='h0001. STATUS read -> 'h0003.
- out_ready=1 continuously while pushing 'h0003,'h0005 -> words emerge in order. Throughput is 1 word per cycle when both push and pop occur; count never exceeds 1.
- Fill 8 words 'h1000..'h1007 (out_ready=0), then push 'hFFFF -> word dropped. STATUS='hC008. Draining yields 'h1000..'h1007 only.
- Full and push while out_ready=1 same cycle -> 'h1000 popped, new word accepted, count stays 8, overflow unchanged.
- Write CTRL 'hF04='h0003 -> out_valid=0 next edge, STATUS='h2000.
- Access 'hF08 and 'h100 while large_ram drives -> block stays hi-Z, no FIFO change.
